// File: rtl/maze_renderer.sv
// Maze wall map with registered pixel lookup and collision query.
// A sweep rebuilds the bordered default maze after reset or clear.
module maze_renderer #(
    parameter int CELL_SHIFT = 5,
    parameter int COLS       = 20,
    parameter int ROWS       = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       wr_en,
    input  logic [3:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic       wr_data,
    input  logic       clear_req,
    input  logic [3:0] q_row,
    input  logic [4:0] q_col,
    output logic       q_wall,
    output logic       busy,
    output logic       is_maze
);

    localparam logic [9:0] ROWS10 = 10'(ROWS);
    localparam logic [9:0] COLS10 = 10'(COLS);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic {
        INIT,
        IDLE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        sweep_q, sweep_d;
    logic [COLS-1:0]   grid_q [ROWS];
    logic [COLS-1:0]   grid_d [ROWS];
    logic              is_maze_q, is_maze_d;
    logic              q_wall_q, q_wall_d;

    logic [9:0]        pix_col, pix_row;
    logic [COLS-1:0]   pix_bits, q_bits;
    logic              pix_in, q_in, wr_ok;

    function automatic logic [COLS-1:0] dflt_row(input int r);
        logic [COLS-1:0] v;
        if (r == 0 || r == ROWS - 1) begin
            v = '1;
        end else begin
            v = '0;
            v[0] = 1'b1;
            v[COLS-1] = 1'b1;
        end
        return v;
    endfunction

    assign busy = (state_q == INIT);

    assign wr_ok = wr_en
                 && ({6'd0, wr_row} < ROWS10)
                 && ({5'd0, wr_col} < COLS10);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        for (int r = 0; r < ROWS; r++) begin
            grid_d[r] = grid_q[r];
        end
        unique case (state_q)
            INIT: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (sweep_q == 4'(r)) begin
                        grid_d[r] = dflt_row(r);
                    end
                end
                sweep_d = sweep_q + 4'd1;
                if (sweep_q == LAST_ROW) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = INIT;
                    sweep_d = 4'd0;
                end else if (wr_ok) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (wr_row == 4'(r)) begin
                            grid_d[r][wr_col] = wr_data;
                        end
                    end
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = 4'd0;
            end
        endcase
    end

    // Reads use grid_q, so a same-cycle write is seen one cycle later.
    always_comb begin
        pix_col  = DrawX >> CELL_SHIFT;
        pix_row  = DrawY >> CELL_SHIFT;
        pix_in   = (pix_col < COLS10) && (pix_row < ROWS10);
        pix_bits = '0;
        q_bits   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (pix_row == 10'(r)) begin
                pix_bits = grid_q[r];
            end
            if (q_row == 4'(r)) begin
                q_bits = grid_q[r];
            end
        end
        is_maze_d = !busy && pix_in && pix_bits[pix_col[4:0]];
        q_in      = ({6'd0, q_row} < ROWS10) && ({5'd0, q_col} < COLS10);
        q_wall_d  = busy || !q_in || q_bits[q_col];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= INIT;
            sweep_q   <= 4'd0;
            is_maze_q <= 1'b0;
            q_wall_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            is_maze_q <= is_maze_d;
            q_wall_q  <= q_wall_d;
        end
    end

    // Grid contents are rebuilt by the sweep, so they need no reset.
    always_ff @(posedge Clk) begin
        for (int r = 0; r < ROWS; r++) begin
            grid_q[r] <= grid_d[r];
        end
    end

    assign is_maze = is_maze_q;
    assign q_wall  = q_wall_q;

endmodule
